// File: rtl/text_blink_ctrl_pkg.sv
// Shared encodings and sizing helpers for the text blink sequencer.
// Optional HOLD end state is enabled by TEXT_BLINK_HOLD_EN.
package text_blink_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArmed = 3'd1,
    StOn    = 3'd2,
    StOff   = 3'd3,
    StHold  = 3'd4
  } blink_state_e;

  localparam int unsigned BLINK_CNT_W = 8;

  // A zero-length phase would never end, so it is stretched to one frame.
  function automatic int unsigned frames_eff(input int unsigned frames);
    return (frames == 0) ? 1 : frames;
  endfunction

  function automatic int unsigned frame_cnt_width(input int unsigned on_frames,
                                                  input int unsigned off_frames);
    int unsigned longest;
    int unsigned width;
    longest = (on_frames > off_frames) ? on_frames : off_frames;
    width   = $clog2(longest);
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/text_blink_ctrl_frame_tick_gen.sv
// Vsync rising-edge detector: combinational tick plus a registered one-cycle frame pulse.
module frame_tick_gen (
  input  logic i_pclk,
  input  logic i_rst_n,
  input  logic i_vsync,
  output logic o_tick,
  output logic o_frame_tick
);

  logic vsync_q;
  logic frame_tick_q;

  assign o_tick       = i_vsync & ~vsync_q;
  assign o_frame_tick = frame_tick_q;

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vsync_q      <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      vsync_q      <= i_vsync;
      frame_tick_q <= o_tick;
    end
  end

endmodule

// File: rtl/text_blink_ctrl.sv
// Frame-synchronous ON/OFF blink sequencer driving the text overlay hide input.
// Define TEXT_BLINK_HOLD_EN to park in a steady-visible HOLD state after the last blink.
module text_blink_ctrl #(
  parameter int unsigned ON_FRAMES     = 30,
  parameter int unsigned OFF_FRAMES    = 30,
  parameter int unsigned BLINK_COUNT   = 0,
  parameter int unsigned MSG_SEL_WIDTH = 2
) (
  input  logic                     i_pclk,
  input  logic                     i_rst_n,
  input  logic                     i_vsync,
  input  logic                     i_start,
  input  logic                     i_stop,
  input  logic [MSG_SEL_WIDTH-1:0] i_msg_sel,
  output logic                     o_hide,
  output logic [MSG_SEL_WIDTH-1:0] o_msg_sel,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_frame_tick
);

  import text_blink_ctrl_pkg::*;

  localparam int unsigned ON_EFF  = frames_eff(ON_FRAMES);
  localparam int unsigned OFF_EFF = frames_eff(OFF_FRAMES);
  localparam int unsigned FRAME_W = frame_cnt_width(ON_EFF, OFF_EFF);

  localparam logic [FRAME_W-1:0]     ON_LAST      = FRAME_W'(ON_EFF - 1);
  localparam logic [FRAME_W-1:0]     OFF_LAST     = FRAME_W'(OFF_EFF - 1);
  localparam logic [BLINK_CNT_W-1:0] BLINK_TGT    = BLINK_CNT_W'(BLINK_COUNT);
  localparam bit                     BLINK_FINITE = (BLINK_COUNT != 0);

  blink_state_e             state_q;
  logic [FRAME_W-1:0]       frame_cnt_q;
  logic [FRAME_W-1:0]       frame_cnt_inc;
  logic [BLINK_CNT_W-1:0]   blink_cnt_q;
  logic [BLINK_CNT_W-1:0]   blink_cnt_inc;
  logic                     stop_pend_q;
  logic                     hide_q;
  logic                     busy_q;
  logic                     done_q;
  logic [MSG_SEL_WIDTH-1:0] msg_sel_q;
  logic                     tick;

  frame_tick_gen u_frame_tick_gen (
    .i_pclk       (i_pclk),
    .i_rst_n      (i_rst_n),
    .i_vsync      (i_vsync),
    .o_tick       (tick),
    .o_frame_tick (o_frame_tick)
  );

  assign frame_cnt_inc = frame_cnt_q + FRAME_W'(1);
  assign blink_cnt_inc = blink_cnt_q + BLINK_CNT_W'(1);

  assign o_hide    = hide_q;
  assign o_msg_sel = msg_sel_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      frame_cnt_q <= '0;
      blink_cnt_q <= '0;
      stop_pend_q <= 1'b0;
      hide_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      msg_sel_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q == StIdle) begin
        // A stop in the same cycle cancels the start.
        if (i_start && !i_stop) begin
          state_q     <= StArmed;
          msg_sel_q   <= i_msg_sel;
          frame_cnt_q <= '0;
          blink_cnt_q <= '0;
          stop_pend_q <= 1'b0;
          hide_q      <= 1'b1;
          busy_q      <= 1'b1;
        end
      end else begin
        if (i_stop) begin
          stop_pend_q <= 1'b1;
        end
        if (tick) begin
          if (stop_pend_q) begin
            state_q     <= StIdle;
            frame_cnt_q <= '0;
            stop_pend_q <= 1'b0;
            hide_q      <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            unique case (state_q)
              StArmed: begin
                state_q     <= StOn;
                frame_cnt_q <= '0;
                hide_q      <= 1'b0;
              end
              StOn: begin
                if (frame_cnt_q == ON_LAST) begin
                  state_q     <= StOff;
                  frame_cnt_q <= '0;
                  hide_q      <= 1'b1;
                end else begin
                  frame_cnt_q <= frame_cnt_inc;
                end
              end
              StOff: begin
                if (frame_cnt_q == OFF_LAST) begin
                  blink_cnt_q <= blink_cnt_inc;
                  frame_cnt_q <= '0;
                  if (BLINK_FINITE && (blink_cnt_inc == BLINK_TGT)) begin
                    done_q <= 1'b1;
`ifdef TEXT_BLINK_HOLD_EN
                    state_q <= StHold;
                    hide_q  <= 1'b0;
`else
                    state_q     <= StIdle;
                    stop_pend_q <= 1'b0;
                    hide_q      <= 1'b1;
                    busy_q      <= 1'b0;
`endif
                  end else begin
                    state_q <= StOn;
                    hide_q  <= 1'b0;
                  end
                end else begin
                  frame_cnt_q <= frame_cnt_inc;
                end
              end
`ifdef TEXT_BLINK_HOLD_EN
              StHold: begin
                hide_q <= 1'b0;
              end
`endif
              default: begin
                state_q     <= StIdle;
                frame_cnt_q <= '0;
                stop_pend_q <= 1'b0;
                hide_q      <= 1'b1;
                busy_q      <= 1'b0;
              end
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_text_blink_ctrl.sv
// Directed bench for text_blink_ctrl: vector table plus reset and free-running blink sequences.
module tb_text_blink_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       a_vsync = 1'b0, a_start = 1'b0, a_stop = 1'b0;
  logic [1:0] a_msg = 2'd0;
  logic       a_hide, a_busy, a_done, a_ftick;
  logic [1:0] a_msel;

  logic       b_vsync = 1'b0, b_start = 1'b0, b_stop = 1'b0;
  logic [1:0] b_msg = 2'd0;
  logic       b_hide, b_busy, b_done, b_ftick;
  logic [1:0] b_msel;

  int n_checks = 0;
  int n_pass   = 0;
  int b_done_count = 0;

  always #5 clk = ~clk;

  text_blink_ctrl #(
    .ON_FRAMES(2), .OFF_FRAMES(3), .BLINK_COUNT(2), .MSG_SEL_WIDTH(2)
  ) dut_a (
    .i_pclk(clk), .i_rst_n(rst_n), .i_vsync(a_vsync), .i_start(a_start), .i_stop(a_stop),
    .i_msg_sel(a_msg), .o_hide(a_hide), .o_msg_sel(a_msel), .o_busy(a_busy),
    .o_done(a_done), .o_frame_tick(a_ftick)
  );

  text_blink_ctrl #(
    .ON_FRAMES(1), .OFF_FRAMES(1), .BLINK_COUNT(0), .MSG_SEL_WIDTH(2)
  ) dut_b (
    .i_pclk(clk), .i_rst_n(rst_n), .i_vsync(b_vsync), .i_start(b_start), .i_stop(b_stop),
    .i_msg_sel(b_msg), .o_hide(b_hide), .o_msg_sel(b_msel), .o_busy(b_busy),
    .o_done(b_done), .o_frame_tick(b_ftick)
  );

  always @(posedge clk) if (b_done === 1'b1) b_done_count <= b_done_count + 1;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h, want %0h", name, got, exp);
    else n_pass++;
  endtask

  typedef struct {
    bit         vs;
    bit         start;
    bit         stop;
    logic [1:0] msg;
    bit         hide;
    bit         busy;
    bit         done;
    logic [1:0] msel;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit vs, input bit start, input bit stop, input logic [1:0] msg,
                     input bit hide, input bit busy, input bit done, input logic [1:0] msel);
    vec_t v;
    v.vs = vs; v.start = start; v.stop = stop; v.msg = msg;
    v.hide = hide; v.busy = busy; v.done = done; v.msel = msel;
    vecs.push_back(v);
  endtask

  // One step: inputs held for one cycle, outputs sampled at the following falling edge.
  task automatic a_step(input bit vs, input bit start, input bit stop, input logic [1:0] msg);
    @(negedge clk);
    a_vsync = vs; a_start = start; a_stop = stop; a_msg = msg;
    @(negedge clk);
    a_vsync = 1'b0; a_start = 1'b0; a_stop = 1'b0;
  endtask

  task automatic b_step(input bit vs, input bit start, input bit stop);
    @(negedge clk);
    b_vsync = vs; b_start = start; b_stop = stop; b_msg = 2'd3;
    @(negedge clk);
    b_vsync = 1'b0; b_start = 1'b0; b_stop = 1'b0;
  endtask

  bit hold_build;
  bit hide_seq[10] = '{0, 0, 1, 1, 1, 0, 0, 1, 1, 1};

  initial begin
`ifdef TEXT_BLINK_HOLD_EN
    hold_build = 1'b1;
`else
    hold_build = 1'b0;
`endif

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_hide", a_hide, 1);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_msel", a_msel, 0);
    check("rst_ftick", a_ftick, 0);
    check("rst_b_hide", b_hide, 1);
    rst_n = 1'b1;

    // Basic sequence with an ignored restart while ON
    add(0, 1, 0, 2'd2, 1, 1, 0, 2'd2);
    add(1, 0, 0, 2'd0, 0, 1, 0, 2'd2);
    add(0, 1, 0, 2'd1, 0, 1, 0, 2'd2);
    for (int k = 1; k < 10; k++) add(1, 0, 0, 2'd0, hide_seq[k], 1, 0, 2'd2);
    // Tick that ends frame 10 completes the second blink
    add(1, 0, 0, 2'd0, !hold_build, hold_build, 1, 2'd2);
    add(0, 0, 0, 2'd0, !hold_build, hold_build, 0, 2'd2);
    add(0, 0, 1, 2'd0, !hold_build, hold_build, 0, 2'd2);
    add(1, 0, 0, 2'd0, 1, 0, 0, 2'd2);
    // Start and stop together in IDLE
    add(0, 1, 1, 2'd3, 1, 0, 0, 2'd2);
    add(1, 0, 0, 2'd0, 1, 0, 0, 2'd2);
    // Stop mid-ON: hide holds until the next tick
    add(0, 1, 0, 2'd1, 1, 1, 0, 2'd1);
    add(1, 0, 0, 2'd0, 0, 1, 0, 2'd1);
    add(0, 0, 1, 2'd0, 0, 1, 0, 2'd1);
    add(0, 0, 0, 2'd0, 0, 1, 0, 2'd1);
    add(1, 0, 0, 2'd0, 1, 0, 0, 2'd1);
    // Stop mid-OFF
    add(0, 1, 0, 2'd3, 1, 1, 0, 2'd3);
    add(1, 0, 0, 2'd0, 0, 1, 0, 2'd3);
    add(1, 0, 0, 2'd0, 0, 1, 0, 2'd3);
    add(1, 0, 0, 2'd0, 1, 1, 0, 2'd3);
    add(0, 0, 1, 2'd0, 1, 1, 0, 2'd3);
    add(0, 0, 0, 2'd0, 1, 1, 0, 2'd3);
    add(1, 0, 0, 2'd0, 1, 0, 0, 2'd3);

    foreach (vecs[i]) begin
      a_step(vecs[i].vs, vecs[i].start, vecs[i].stop, vecs[i].msg);
      check($sformatf("v%0d_hide", i), a_hide, vecs[i].hide);
      check($sformatf("v%0d_busy", i), a_busy, vecs[i].busy);
      check($sformatf("v%0d_done", i), a_done, vecs[i].done);
      check($sformatf("v%0d_msel", i), a_msel, vecs[i].msel);
      check($sformatf("v%0d_ftick", i), a_ftick, vecs[i].vs);
    end

    // Asynchronous reset while ON
    a_step(0, 1, 0, 2'd2);
    a_step(1, 0, 0, 2'd0);
    check("pre_rst_hide", a_hide, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_hide", a_hide, 1);
    check("async_rst_busy", a_busy, 0);
    check("async_rst_done", a_done, 0);
    check("async_rst_msel", a_msel, 0);
    @(negedge clk);
    rst_n = 1'b1;
    a_step(1, 0, 0, 2'd0);
    check("post_rst_hide", a_hide, 1);
    check("post_rst_busy", a_busy, 0);
    check("post_rst_done", a_done, 0);

    // Endless blink, ON=1 OFF=1: blink counter wraps past 255 unnoticed
    b_step(0, 1, 0);
    check("inf_armed_busy", b_busy, 1);
    for (int k = 1; k <= 600; k++) begin
      b_step(1, 0, 0);
      check($sformatf("inf_t%0d_hide", k), b_hide, (k % 2 == 0) ? 1 : 0);
      check($sformatf("inf_t%0d_busy", k), b_busy, 1);
    end
    check("inf_no_done", b_done_count, 0);
    b_step(0, 0, 1);
    b_step(1, 0, 0);
    check("inf_stop_hide", b_hide, 1);
    check("inf_stop_busy", b_busy, 0);
    check("inf_stop_done", b_done_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
